// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Two-port round-robin arbiter in front of a single-port memory bank.
//   A request seen while idle is latched, granted for exactly one ACCESS
//   cycle, and (for reads) the bank's combinational read data is captured
//   at the end of that cycle and flagged with a one-cycle rvalid pulse on
//   the winning port. At most one access completes every two cycles.
//
// Ports:
//   clk                 sole clock, all state updates on its rising edge
//   rst                 synchronous active-high reset
//   req0/we0/addr0/wdata0   port 0 request, write enable, address, data
//   gnt0/rvalid0/rdata0     port 0 grant pulse, read-valid pulse, read data
//   req1/we1/addr1/wdata1   port 1 request, write enable, address, data
//   gnt1/rvalid1/rdata1     port 1 grant pulse, read-valid pulse, read data
//   mem_addr/mem_we/mem_wdata   address, write strobe, write data to bank
//   mem_rdata           combinational read data from bank at mem_addr
//   busy                high while the arbiter is in its ACCESS state
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 6,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,

  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,

  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state;

  // Round-robin pointer: the port that wins the next tie.
  logic          ptr;

  // Identity and direction of the access currently in flight. mem_addr and
  // mem_wdata double as the latched address/data, since they must hold
  // their last value outside ACCESS anyway.
  logic          win;
  logic          lat_we;

  // Arbitration decision for this cycle, plus the winner's request fields
  // steered through a single mux so the FSM only deals with one request.
  logic          any_req;
  logic          pick1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Decide which port would win if we were to grant right now. A lone
  // requester always wins; on a tie the round-robin pointer decides.
  always_comb begin
    any_req = req0 | req1;
    pick1   = 1'b0;
    if (req0 && req1) begin
      pick1 = ptr;
    end else if (req1) begin
      pick1 = 1'b1;
    end
    sel_we    = pick1 ? we1    : we0;
    sel_addr  = pick1 ? addr1  : addr0;
    sel_wdata = pick1 ? wdata1 : wdata0;
  end

  // Main controller. Every output is registered so that grant, strobe and
  // busy line up exactly with the ACCESS cycle, and the read-valid pulse
  // lands in the cycle right after it. Pulse outputs default low each
  // cycle and are only raised by the state that owns them. Reset wins over
  // everything, which also aborts an in-flight read before its rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      win       <= 1'b0;
      lat_we    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            win       <= pick1;
            ptr       <= ~pick1;
            lat_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
          end
        end

        ACCESS: begin
          // The access is always a single cycle; requests seen now are
          // ignored and will be picked up on the next idle cycle.
          state <= IDLE;
          if (!lat_we) begin
            if (win) begin
              rdata1  <= mem_rdata;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_rdata;
              rvalid0 <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Directed self-checking bench for mem_arbiter. A 64-word bank model
//   preloaded with word[i] = i sits behind the memory port; expected values
//   below are worked out by hand from the intended cycle behaviour.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, rvalid0, gnt1, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  logic [DW-1:0] bank [64];

  int errors = 0;
  int checks = 0;

  // 10 ns clock.
  always #5 clk = ~clk;

  // Memory bank: combinational read, write on the rising edge when strobed.
  assign mem_rdata = bank[mem_addr];

  always @(posedge clk) begin
    if (mem_we) bank[mem_addr] <= mem_wdata;
  end

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .rdata0   (rdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata1   (rdata1),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  // Advance one clock and settle just after the edge, where both inputs
  // are driven and registered outputs are sampled.
  task step;
    @(posedge clk);
    #1;
  endtask

  task applyStimulus(input logic r0, input logic w0, input logic [AW-1:0] a0,
                     input logic [DW-1:0] d0,
                     input logic r1, input logic w1, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task checkOutput(input string tag, input logic [31:0] got,
                   input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated access on a single port: request, check the grant cycle,
  // drop the request, check the completion cycle.
  task runAccess(input string tag, input logic port, input logic we,
                 input logic [AW-1:0] a, input logic [DW-1:0] d,
                 input logic [DW-1:0] exp_rd);
    if (port == 1'b0) applyStimulus(1'b1, we, a, d, 1'b0, 1'b0, '0, '0);
    else              applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, we, a, d);
    step;
    checkOutput({tag, ".gnt0"},     gnt0,     (port == 1'b0));
    checkOutput({tag, ".gnt1"},     gnt1,     (port == 1'b1));
    checkOutput({tag, ".busy"},     busy,     1);
    checkOutput({tag, ".mem_we"},   mem_we,   we);
    checkOutput({tag, ".mem_addr"}, mem_addr, a);
    if (we) checkOutput({tag, ".mem_wdata"}, mem_wdata, d);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step;
    checkOutput({tag, ".rvalid0"}, rvalid0, (!we && port == 1'b0));
    checkOutput({tag, ".rvalid1"}, rvalid1, (!we && port == 1'b1));
    checkOutput({tag, ".mem_we_off"}, mem_we, 0);
    checkOutput({tag, ".busy_off"},   busy,   0);
    if (!we) begin
      if (port == 1'b0) checkOutput({tag, ".rdata0"}, rdata0, exp_rd);
      else              checkOutput({tag, ".rdata1"}, rdata1, exp_rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) bank[i] = DW'(i);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step;
    step;

    // Reset state.
    checkOutput("rst.gnt0",     gnt0,     0);
    checkOutput("rst.gnt1",     gnt1,     0);
    checkOutput("rst.rvalid0",  rvalid0,  0);
    checkOutput("rst.rvalid1",  rvalid1,  0);
    checkOutput("rst.busy",     busy,     0);
    checkOutput("rst.mem_we",   mem_we,   0);
    checkOutput("rst.mem_addr", mem_addr, 0);
    checkOutput("rst.rdata0",   rdata0,   0);
    rst = 1'b0;
    step;

    // A request that vanishes before an edge samples it is ignored.
    req0 = 1'b1; addr0 = 6'd9;
    #3;
    req0 = 1'b0;
    step;
    checkOutput("glitch.gnt0", gnt0, 0);
    checkOutput("glitch.busy", busy, 0);

    // Single read of address 33; changes during ACCESS must not matter.
    applyStimulus(1'b1, 1'b0, 6'd33, '0, 1'b0, 1'b0, '0, '0);
    step;
    checkOutput("rd33.gnt0",     gnt0,     1);
    checkOutput("rd33.mem_addr", mem_addr, 33);
    applyStimulus(1'b0, 1'b1, 6'd7, 20'h11111, 1'b0, 1'b0, '0, '0);
    step;
    checkOutput("rd33.gnt0_off", gnt0,    0);
    checkOutput("rd33.rvalid0",  rvalid0, 1);
    checkOutput("rd33.rdata0",   rdata0,  33);
    checkOutput("rd33.bank7",    bank[7], 7);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step;
    checkOutput("rd33.rvalid0_off", rvalid0, 0);
    checkOutput("rd33.rdata0_hold", rdata0,  33);

    // Contention after a fresh reset: port 0 first, then port 1.
    rst = 1'b1;
    step;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 6'd1, '0, 1'b1, 1'b0, 6'd63, '0);
    step;
    checkOutput("tie.a.gnt0", gnt0, 1);
    checkOutput("tie.a.gnt1", gnt1, 0);
    req0 = 1'b0;
    step;
    checkOutput("tie.a.rvalid0", rvalid0, 1);
    checkOutput("tie.a.rdata0",  rdata0,  1);
    checkOutput("tie.a.gnt1_wait", gnt1,  0);
    step;
    checkOutput("tie.b.gnt1",     gnt1,     1);
    checkOutput("tie.b.mem_addr", mem_addr, 63);
    req1 = 1'b0;
    step;
    checkOutput("tie.b.rvalid1", rvalid1, 1);
    checkOutput("tie.b.rdata1",  rdata1,  63);
    req0 = 1'b1; req1 = 1'b1;
    step;
    checkOutput("tie.c.gnt0", gnt0, 1);
    checkOutput("tie.c.gnt1", gnt1, 0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step;

    // Port 1 writes 48, port 0 reads it back; rdata1 is untouched.
    runAccess("wr48", 1'b1, 1'b1, 6'd48, 20'hABCDE, '0);
    checkOutput("wr48.rdata1_hold", rdata1, 63);
    runAccess("rd48", 1'b0, 1'b0, 6'd48, '0, 20'hABCDE);

    // Both ports requesting for 10 cycles from reset: grants alternate.
    rst = 1'b1;
    step;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 6'd5, '0, 1'b1, 1'b0, 6'd10, '0);
    for (int i = 0; i < 10; i++) begin
      step;
      checkOutput($sformatf("rr%0d.gnt0", i), gnt0, (i % 4 == 0));
      checkOutput($sformatf("rr%0d.gnt1", i), gnt1, (i % 4 == 2));
      checkOutput($sformatf("rr%0d.excl", i), gnt0 & gnt1, 0);
      checkOutput($sformatf("rr%0d.rvalid0", i), rvalid0, (i % 4 == 1));
      checkOutput($sformatf("rr%0d.rvalid1", i), rvalid1, (i % 4 == 3));
    end
    checkOutput("rr.rdata0", rdata0, 5);
    checkOutput("rr.rdata1", rdata1, 10);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step;

    // Reset in the middle of a port 1 read of address 16.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 6'd16, '0);
    step;
    checkOutput("abort.gnt1", gnt1, 1);
    rst = 1'b1;
    req1 = 1'b0;
    step;
    checkOutput("abort.rvalid1",  rvalid1,  0);
    checkOutput("abort.gnt1_off", gnt1,     0);
    checkOutput("abort.busy",     busy,     0);
    checkOutput("abort.mem_addr", mem_addr, 0);
    checkOutput("abort.rdata1",   rdata1,   0);
    rst = 1'b0;
    step;
    checkOutput("abort.rvalid1_late", rvalid1, 0);
    req0 = 1'b1; req1 = 1'b1;
    step;
    checkOutput("abort.tie.gnt0", gnt0, 1);
    checkOutput("abort.tie.gnt1", gnt1, 0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step;

    // Boundary addresses on both ports.
    runAccess("p0wr0",  1'b0, 1'b1, 6'd0,  20'h12345, '0);
    runAccess("p1wr63", 1'b1, 1'b1, 6'd63, 20'h54321, '0);
    runAccess("p1rd0",  1'b1, 1'b0, 6'd0,  '0, 20'h12345);
    runAccess("p0rd63", 1'b0, 1'b0, 6'd63, '0, 20'h54321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 6, address width (64-word bank).
REQ-002 Parameter DW, default 20, data word width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high, sampled on rising edge of clk.
REQ-005 req0  input  1  port 0 access request; held high until gnt0.
REQ-006 we0  input  1  port 0 write enable (1 = write, 0 = read).
REQ-007 addr0  input  AW  port 0 word address.
REQ-008 wdata0  input  DW  port 0 write data.
REQ-009 gnt0  output  1  port 0 grant pulse.
REQ-010 rvalid0  output  1  port 0 read-data-valid pulse.
REQ-011 rdata0  output  DW  port 0 read data.
REQ-012 req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1 have the same directions, widths and meanings for port 1.
REQ-013 mem_addr  output  AW  address to memory bank.
REQ-014 mem_we  output  1  write strobe to memory bank.
REQ-015 mem_wdata  output  DW  write data to memory bank.
REQ-016 mem_rdata  input  DW  combinational read data from bank at mem_addr.
REQ-017 busy  output  1  high while state is ACCESS.

Function
REQ-018 FSM has two states: IDLE and ACCESS; reset state is IDLE.
REQ-019 IDLE, no req: stay in IDLE; all pulse outputs low.
REQ-020 IDLE, req0 or req1 high: pick winner, latch winner's we/addr/wdata into internal registers, record winner id, go to ACCESS next cycle.
REQ-021 Arbitration: single requester wins; both requesting -> port indicated by priority pointer wins.
REQ-022 Priority pointer: reset value 0; after each grant it points to the non-winning port (round-robin).
REQ-023 ACCESS lasts exactly one cycle, then returns to IDLE unconditionally.
REQ-024 In ACCESS: mem_addr = latched addr, mem_wdata = latched wdata, mem_we = latched we; gnt of winner high for that cycle only.
REQ-025 Outside ACCESS: mem_we = 0; mem_addr and mem_wdata hold last latched values.
REQ-026 Read (latched we = 0): mem_rdata is registered into winner's rdata at the end of ACCESS; winner's rvalid is high for exactly the following cycle.
REQ-027 Write: no rvalid pulse; rdataN unchanged.
REQ-028 rdataN holds its value until the next read completes on that port.
REQ-029 Latency: req sampled in IDLE at edge N -> gnt and mem strobe during cycle N+1 -> rvalid during cycle N+2.
REQ-030 Throughput: at most one access per two cycles; back-to-back contending requests alternate ports.
REQ-031 A req dropped before being sampled in IDLE is ignored; req/addr/we/wdata changes during ACCESS have no effect on the current access.
REQ-032 gnt0 and gnt1 never high together; rvalid0 and rvalid1 never high together.
REQ-033 Writes to one port and reads from the other never reorder: accesses complete in grant order.

Reset
REQ-034 rst high at a rising edge: state <= IDLE, pointer <= 0, gnt0/gnt1/rvalid0/rvalid1/mem_we/busy <= 0, rdata0/rdata1/mem_addr/mem_wdata <= 0.
REQ-035 rst asserted during ACCESS aborts the access: no rvalid pulse follows; mem_we low from the next cycle.
REQ-036 rst has priority over all requests in the same cycle.

Verification
REQ-037 Single read: bank preloaded word[i] = i; req0=1, we0=0, addr0=6'd33 -> gnt0 one cycle later, rvalid0 the cycle after, rdata0 = 20'd33.
REQ-038 Contention: req0 and req1 both high after reset, addr0=1, addr1=63, reads -> port 0 granted first (rdata0 = 1), then port 1 (rdata1 = 63); next tie goes to port 0 again.
REQ-039 Write-then-read: port 1 writes 20'hABCDE to addr 6'd48, then port 0 reads addr 48 -> mem_we high exactly one cycle, rvalid0 with rdata0 = 20'hABCDE.
REQ-040 Continuous requests from both ports for 10 cycles -> grants alternate 0,1,0,1,...; one grant per two cycles; gnt0/gnt1 never simultaneous.
REQ-041 Reset mid-ACCESS on a read to addr 6'd16 -> no rvalid, state IDLE, all outputs 0, next tie grants port 0.
REQ-042 Boundary addresses 6'd0 and 6'd63 read and write correctly on both ports.
